pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Pipeline sequencing controller that drives the enable and flush inputs of the fetch/decode and decode/ALU pipeline buffers and the PC register. It resolves three conditions: load-use stalls, taken-branch flushes and multi-cycle interrupt entry. It also holds the front end on a halt. It sits beside the decode stage and takes hazard information from the decode and ALU (EX) stages.

## Interface
- INT_CYCLES, 2: number of cycles the interrupt entry sequence occupies (PC/flag push slots). Must be ≥ 1.
- REG_W, 3: register-index width.

Ports:
- clk  in  1  system clock. State updates on posedge; the buffers sample on negedge.
- rst  in  1  synchronous, active-high reset.
- i_dec_rsrc1, i_dec_rsrc2  in  REG_W  source registers of the instruction in decode.
- i_dec_use1, i_dec_use2  in  1  decode instruction actually reads rsrc1 / rsrc2.
- i_dec_hlt  in  1  HLT decoded this cycle.
- i_ex_mem_read  in  1  instruction in EX is a memory load.
- i_ex_rdst  in  REG_W  destination of the instruction in EX.
- i_ex_branch_taken  in  1  branch resolved taken in EX this cycle.
- i_int_req  in  1  interrupt request pulse (≥ 1 cycle).
- o_pc_en  out  1  PC register load enable.
- o_fd_en, o_fd_flush  out  1  fetch/decode buffer enable / flush.
- o_de_en, o_de_flush  out  1  decode/ALU buffer enable / flush (drives its rst).
- o_int_active  out  1  interrupt sequence in progress. Drives the buffer INT bit.
- o_int_step  out  $clog2(INT_CYCLES+1)  current sequence step.
- o_int_done  out  1  one-cycle pulse on the final step; the datapath loads the vector into the PC.
- o_halted  out  1  controller is in HALT.

## Operation
- States: RUN, INT_SEQ, HALT. Registered: state, step counter, int_pending.
- int_pending is set by i_int_req in any state. It is cleared on entry to INT_SEQ.
- Load-use hazard (lu) = i_ex_mem_read & ((i_dec_use1 & i_dec_rsrc1==i_ex_rdst) | (i_dec_use2 & i_dec_rsrc2==i_ex_rdst)).
- Per-cycle priority in RUN: branch > lu > interrupt entry > halt > normal.
  - Branch: pc_en=1, fd_flush=1, de_flush=1. A coincident lu is discarded because the stalled instruction is flushed. Interrupt entry is deferred one cycle.
  - lu: pc_en=0, fd_en=0, de_flush=1 (bubble into EX). The stall lasts one cycle. No state change.
  - Interrupt entry: when int_pending (or i_int_req this cycle) is set and there is no branch or lu, go to INT_SEQ next cycle with step=0.
  - Halt: i_dec_hlt with none of the above → HALT next cycle.
  - Normal: all enables 1, all flushes 0.
- INT_SEQ:
  - Outputs: pc_en=0, fd_en=1, fd_flush=1, de_en=1, int_active=1.
  - Step increments each cycle. On step==INT_CYCLES-1: int_done=1, pc_en=1, next state RUN, step cleared.
  - Branch and lu inputs are ignored in this state.
- HALT:
  - Outputs: pc_en=0, fd_en=0, fd_flush=1. de_en stays 1 so the back end drains bubbles.
  - Exits to INT_SEQ when int_pending is set. Otherwise it stays until rst.
- Reset:
  - Next state RUN, step 0, int_pending cleared. A request coincident with rst is dropped.
  - While rst=1, outputs are forced: pc_en=0, fd_en=0, de_en=0, fd_flush=1, de_flush=1, int_active=0, int_step=0, int_done=0, halted=0.
  - Reset mid-INT_SEQ aborts the sequence; int_done is not issued.

## Timing
- Outputs are combinational from registered state plus current-cycle hazard inputs. They must settle within the first half cycle so they are valid at the buffers' negedge.
- Load-use stall: 1 cycle. Branch flush: 1 cycle, same cycle as i_ex_branch_taken.
- Interrupt latency: request in cycle N (RUN, no hazard) → INT_SEQ in N+1 … N+INT_CYCLES. int_done occurs in cycle N+INT_CYCLES, and RUN resumes in N+INT_CYCLES+1.
- Back-to-back interrupts: a request during INT_SEQ is held pending. It re-enters INT_SEQ on the first eligible RUN cycle, which is at least 1 RUN cycle after the sequence ends.

## Configuration
- PIPE_INT_SEQ_EN defined: full behaviour as described above.
- PIPE_INT_SEQ_EN undefined:
  - The INT_SEQ state, step counter and int_pending are not built, and i_int_req is ignored.
  - o_int_active, o_int_step and o_int_done are tied to 0.
  - HALT exits only by rst.

## Structure
- Shared package pipe_ctrl_pkg: state enum (RUN, INT_SEQ, HALT) and the default INT_CYCLES constant.
- Sub-module pipe_lu_detect: purely combinational lu compare. It is reused by a future forwarding unit.

## Test plan
- Load-use: i_ex_mem_read=1, i_ex_rdst=3, i_dec_rsrc1=3, use1=1 → exactly one cycle with pc_en=0, fd_en=0, de_flush=1; then all enables are 1.
- Branch + lu in the same cycle → fd_flush=1, de_flush=1, pc_en=1; no stall the following cycle.
- INT_CYCLES=2, i_int_req pulse in RUN → int_active for 2 cycles, int_step 0 then 1, int_done on step 1, RUN afterwards.
- i_int_req during INT_SEQ → second sequence starts after 1 RUN cycle.
- i_dec_hlt → o_halted=1, pc_en=0 held; interrupt pulse → INT_SEQ, then RUN.
- rst asserted at step 0 of INT_SEQ → next cycle RUN with all outputs at reset values; no int_done seen.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: the controller
// state encoding and the default length of the interrupt entry sequence.
package pipe_ctrl_pkg;

    // Controller states. INT_SEQ is only reachable when the interrupt
    // sequencer is built (PIPE_INT_SEQ_EN).
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_INT_SEQ = 2'd1,
        ST_HALT    = 2'd2
    } pipe_state_e;

    // Default number of cycles spent pushing PC/flags on interrupt entry.
    localparam int INT_CYCLES_DEF = 2;

endpackage : pipe_ctrl_pkg

// File: rtl/pipe_lu_detect.sv
// Load-use hazard detector: flags a decode-stage instruction that reads the
// destination of a load currently in EX. Purely combinational so it can be
// shared with a forwarding unit.
module pipe_lu_detect #(
    parameter int REG_W = 3
) (
    input  logic [REG_W-1:0] i_dec_rsrc1,
    input  logic [REG_W-1:0] i_dec_rsrc2,
    input  logic             i_dec_use1,
    input  logic             i_dec_use2,
    input  logic             i_ex_mem_read,
    input  logic [REG_W-1:0] i_ex_rdst,
    output logic             o_lu
);

    // A source only creates a hazard when the instruction actually reads it.
    function automatic logic src_hit(input logic             use_src,
                                     input logic [REG_W-1:0] rsrc,
                                     input logic [REG_W-1:0] rdst);
        return use_src && (rsrc == rdst);
    endfunction

    // Hazard exists only while the EX instruction is a load.
    always_comb begin
        o_lu = i_ex_mem_read &&
               (src_hit(i_dec_use1, i_dec_rsrc1, i_ex_rdst) ||
                src_hit(i_dec_use2, i_dec_rsrc2, i_ex_rdst));
    end

endmodule : pipe_lu_detect

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: drives PC enable and the enable/flush of
// the fetch/decode and decode/ALU buffers. Resolves load-use stalls, taken
// branch flushes, multi-cycle interrupt entry and halt.
// Optional feature macro: PIPE_INT_SEQ_EN builds the interrupt sequencer
// (INT_SEQ state, step counter, pending flag). Without it i_int_req is
// ignored, the interrupt outputs are tied low and HALT exits only by rst.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int INT_CYCLES = INT_CYCLES_DEF,
    parameter int REG_W      = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [REG_W-1:0]                i_dec_rsrc1,
    input  logic [REG_W-1:0]                i_dec_rsrc2,
    input  logic                            i_dec_use1,
    input  logic                            i_dec_use2,
    input  logic                            i_dec_hlt,
    input  logic                            i_ex_mem_read,
    input  logic [REG_W-1:0]                i_ex_rdst,
    input  logic                            i_ex_branch_taken,
    input  logic                            i_int_req,
    output logic                            o_pc_en,
    output logic                            o_fd_en,
    output logic                            o_fd_flush,
    output logic                            o_de_en,
    output logic                            o_de_flush,
    output logic                            o_int_active,
    output logic [$clog2(INT_CYCLES+1)-1:0] o_int_step,
    output logic                            o_int_done,
    output logic                            o_halted
);

    localparam int SW = $clog2(INT_CYCLES + 1);

    logic        lu;
    pipe_state_e state_q, state_d;

    pipe_lu_detect #(
        .REG_W (REG_W)
    ) u_lu_detect (
        .i_dec_rsrc1   (i_dec_rsrc1),
        .i_dec_rsrc2   (i_dec_rsrc2),
        .i_dec_use1    (i_dec_use1),
        .i_dec_use2    (i_dec_use2),
        .i_ex_mem_read (i_ex_mem_read),
        .i_ex_rdst     (i_ex_rdst),
        .o_lu          (lu)
    );

`ifdef PIPE_INT_SEQ_EN
    localparam logic [SW-1:0] LAST_STEP = SW'(INT_CYCLES - 1);

    logic [SW-1:0] step_q, step_d;
    logic          int_pending_q, int_pending_d;
    logic          int_want;
    logic          last_step;

    // In RUN a request seen this cycle is as good as one already pending.
    assign int_want  = int_pending_q | i_int_req;
    assign last_step = (step_q == LAST_STEP);

    // Step counter and pending-interrupt flag; a request during rst is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            step_q        <= '0;
            int_pending_q <= 1'b0;
        end else begin
            step_q        <= step_d;
            int_pending_q <= int_pending_d;
        end
    end
`else
    // Request input has no consumer when the sequencer is not built.
    logic unused_int_req;
    assign unused_int_req = i_int_req;

    assign o_int_active = 1'b0;
    assign o_int_step   = '0;
    assign o_int_done   = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: branch > load-use > interrupt entry > halt > normal.
    always_comb begin
        state_d = state_q;
`ifdef PIPE_INT_SEQ_EN
        step_d        = step_q;
        // Requests accumulate in every state; entry to INT_SEQ consumes them.
        int_pending_d = int_pending_q | i_int_req;
`endif
        case (state_q)
            ST_RUN: begin
                if (i_ex_branch_taken || lu) begin
                    // Flush or stall cycle: interrupt/halt wait for a clean cycle.
                    state_d = ST_RUN;
`ifdef PIPE_INT_SEQ_EN
                end else if (int_want) begin
                    state_d       = ST_INT_SEQ;
                    step_d        = '0;
                    int_pending_d = 1'b0;
`endif
                end else if (i_dec_hlt) begin
                    state_d = ST_HALT;
                end
            end
`ifdef PIPE_INT_SEQ_EN
            ST_INT_SEQ: begin
                // Hazard inputs are ignored while the push slots run.
                if (last_step) begin
                    state_d = ST_RUN;
                    step_d  = '0;
                end else begin
                    step_d = step_q + SW'(1);
                end
            end
`endif
            ST_HALT: begin
`ifdef PIPE_INT_SEQ_EN
                if (int_pending_q) begin
                    state_d       = ST_INT_SEQ;
                    step_d        = '0;
                    int_pending_d = 1'b0;
                end
`else
                state_d = ST_HALT;
`endif
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Output logic: from registered state plus current hazard inputs, forced
    // to the safe values while rst is held.
    always_comb begin
        o_pc_en      = 1'b1;
        o_fd_en      = 1'b1;
        o_fd_flush   = 1'b0;
        o_de_en      = 1'b1;
        o_de_flush   = 1'b0;
        o_halted     = 1'b0;
`ifdef PIPE_INT_SEQ_EN
        o_int_active = 1'b0;
        o_int_step   = '0;
        o_int_done   = 1'b0;
`endif
        case (state_q)
            ST_RUN: begin
                if (i_ex_branch_taken) begin
                    // Wrong-path instructions in F/D and D/E are discarded;
                    // a coincident load-use stall dies with them.
                    o_fd_flush = 1'b1;
                    o_de_flush = 1'b1;
                end else if (lu) begin
                    // Hold PC and F/D, inject a bubble into EX.
                    o_pc_en    = 1'b0;
                    o_fd_en    = 1'b0;
                    o_de_flush = 1'b1;
                end
            end
`ifdef PIPE_INT_SEQ_EN
            ST_INT_SEQ: begin
                // PC loads only on the last step, when the vector is applied.
                o_pc_en      = last_step;
                o_fd_flush   = 1'b1;
                o_int_active = 1'b1;
                o_int_step   = step_q;
                o_int_done   = last_step;
            end
`endif
            ST_HALT: begin
                // Front end frozen; back end keeps draining bubbles.
                o_pc_en    = 1'b0;
                o_fd_en    = 1'b0;
                o_fd_flush = 1'b1;
                o_halted   = 1'b1;
            end
            default: begin
                o_pc_en = 1'b1;
            end
        endcase

        if (rst) begin
            o_pc_en      = 1'b0;
            o_fd_en      = 1'b0;
            o_fd_flush   = 1'b1;
            o_de_en      = 1'b0;
            o_de_flush   = 1'b1;
            o_halted     = 1'b0;
`ifdef PIPE_INT_SEQ_EN
            o_int_active = 1'b0;
            o_int_step   = '0;
            o_int_done   = 1'b0;
`endif
        end
    end

endmodule : pipe_hazard_ctrl

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl (INT_CYCLES=2, REG_W=3).
// Expectations follow the build: with PIPE_INT_SEQ_EN the interrupt sequence
// is expected, otherwise interrupt requests must have no effect.
module tb_pipe_hazard_ctrl;

    localparam int INT_CYCLES = 2;
    localparam int REG_W      = 3;
`ifdef PIPE_INT_SEQ_EN
    localparam bit INT_EN = 1'b1;
`else
    localparam bit INT_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [REG_W-1:0] i_dec_rsrc1, i_dec_rsrc2, i_ex_rdst;
    logic             i_dec_use1, i_dec_use2, i_dec_hlt;
    logic             i_ex_mem_read, i_ex_branch_taken, i_int_req;
    logic             o_pc_en, o_fd_en, o_fd_flush, o_de_en, o_de_flush;
    logic             o_int_active, o_int_done, o_halted;
    logic [1:0]       o_int_step;

    int checks   = 0;
    int failures = 0;

    pipe_hazard_ctrl #(
        .INT_CYCLES (INT_CYCLES),
        .REG_W      (REG_W)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .i_dec_rsrc1       (i_dec_rsrc1),
        .i_dec_rsrc2       (i_dec_rsrc2),
        .i_dec_use1        (i_dec_use1),
        .i_dec_use2        (i_dec_use2),
        .i_dec_hlt         (i_dec_hlt),
        .i_ex_mem_read     (i_ex_mem_read),
        .i_ex_rdst         (i_ex_rdst),
        .i_ex_branch_taken (i_ex_branch_taken),
        .i_int_req         (i_int_req),
        .o_pc_en           (o_pc_en),
        .o_fd_en           (o_fd_en),
        .o_fd_flush        (o_fd_flush),
        .o_de_en           (o_de_en),
        .o_de_flush        (o_de_flush),
        .o_int_active      (o_int_active),
        .o_int_step        (o_int_step),
        .o_int_done        (o_int_done),
        .o_halted          (o_halted)
    );

    always #5 clk = ~clk;

    // Observed outputs packed as {pc_en, fd_en, fd_flush, de_en, de_flush,
    // int_active, int_step[1:0], int_done, halted}.
    logic [9:0] obs;
    assign obs = {o_pc_en, o_fd_en, o_fd_flush, o_de_en, o_de_flush,
                  o_int_active, o_int_step, o_int_done, o_halted};

    function automatic logic [9:0] ex(input logic pc, fe, ff, de, df, ia,
                                      input logic [1:0] st,
                                      input logic dn, h);
        return {pc, fe, ff, de, df, ia, st, dn, h};
    endfunction

    localparam logic [9:0] E_NORM = {1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,2'd0,1'b0,1'b0};
    localparam logic [9:0] E_LU   = {1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'd0,1'b0,1'b0};
    localparam logic [9:0] E_BR   = {1'b1,1'b1,1'b1,1'b1,1'b1,1'b0,2'd0,1'b0,1'b0};
    localparam logic [9:0] E_RST  = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'd0,1'b0,1'b0};
    localparam logic [9:0] E_HALT = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'd0,1'b0,1'b1};
    localparam logic [9:0] E_INT0 = {1'b0,1'b1,1'b1,1'b1,1'b0,1'b1,2'd0,1'b0,1'b0};
    localparam logic [9:0] E_INT1 = {1'b1,1'b1,1'b1,1'b1,1'b0,1'b1,2'd1,1'b1,1'b0};

    // Inputs change 1 time unit after posedge; outputs are sampled at negedge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_dec_rsrc1       = '0;
        i_dec_rsrc2       = '0;
        i_ex_rdst         = 3'd7;
        i_dec_use1        = 1'b0;
        i_dec_use2        = 1'b0;
        i_dec_hlt         = 1'b0;
        i_ex_mem_read     = 1'b0;
        i_ex_branch_taken = 1'b0;
        i_int_req         = 1'b0;
    endtask

    task automatic test_reset();
        logic [9:0] e;
        idle_inputs();
        rst = 1'b1;
        i_ex_branch_taken = 1'b1;
        i_int_req = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== E_RST) begin failures++; $display("FAIL rst_forced obs=%b exp=%b", obs, E_RST); end
        next_cycle();
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        checks++;
        if (obs !== E_NORM) begin failures++; $display("FAIL after_rst obs=%b exp=%b", obs, E_NORM); end
        next_cycle();
        @(negedge clk);
        e = E_NORM;
        checks++;
        if (obs !== e) begin failures++; $display("FAIL rst_req_dropped obs=%b exp=%b", obs, e); end
        next_cycle();
    endtask

    task automatic test_load_use();
        i_ex_mem_read = 1'b1; i_ex_rdst = 3'd3; i_dec_rsrc1 = 3'd3; i_dec_use1 = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== E_LU) begin failures++; $display("FAIL lu_rs1 obs=%b exp=%b", obs, E_LU); end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (obs !== E_NORM) begin failures++; $display("FAIL lu_release obs=%b exp=%b", obs, E_NORM); end
        next_cycle();
        i_ex_mem_read = 1'b1; i_ex_rdst = 3'd5; i_dec_rsrc2 = 3'd5; i_dec_use2 = 1'b1;
        i_dec_rsrc1 = 3'd1; i_dec_use1 = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== E_LU) begin failures++; $display("FAIL lu_rs2 obs=%b exp=%b", obs, E_LU); end
        next_cycle();
        i_dec_use2 = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== E_NORM) begin failures++; $display("FAIL lu_src_unused obs=%b exp=%b", obs, E_NORM); end
        next_cycle();
        i_dec_use2 = 1'b1; i_ex_mem_read = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== E_NORM) begin failures++; $display("FAIL lu_not_load obs=%b exp=%b", obs, E_NORM); end
        next_cycle();
        i_ex_mem_read = 1'b1; i_ex_rdst = 3'd4;
        @(negedge clk);
        checks++;
        if (obs !== E_NORM) begin failures++; $display("FAIL lu_no_match obs=%b exp=%b", obs, E_NORM); end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_branch_lu();
        i_ex_branch_taken = 1'b1;
        i_ex_mem_read = 1'b1; i_ex_rdst = 3'd3; i_dec_rsrc1 = 3'd3; i_dec_use1 = 1'b1;
        i_dec_hlt = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== E_BR) begin failures++; $display("FAIL br_lu obs=%b exp=%b", obs, E_BR); end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (obs !== E_NORM) begin failures++; $display("FAIL br_no_stall obs=%b exp=%b", obs, E_NORM); end
        next_cycle();
    endtask

    task automatic test_interrupt();
        logic [9:0] e;
        i_int_req = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== E_NORM) begin failures++; $display("FAIL int_req_cycle obs=%b exp=%b", obs, E_NORM); end
        next_cycle();
        i_int_req = 1'b0;
        // Load-use inputs present during the sequence must be ignored.
        i_ex_mem_read = 1'b1; i_ex_rdst = 3'd2; i_dec_rsrc1 = 3'd2; i_dec_use1 = 1'b1;
        @(negedge clk);
        e = INT_EN ? E_INT0 : E_LU;
        checks++;
        if (obs !== e) begin failures++; $display("FAIL int_step0 obs=%b exp=%b", obs, e); end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        e = INT_EN ? E_INT1 : E_NORM;
        checks++;
        if (obs !== e) begin failures++; $display("FAIL int_step1_done obs=%b exp=%b", obs, e); end
        next_cycle();
        @(negedge clk);
        checks++;
        if (obs !== E_NORM) begin failures++; $display("FAIL int_resume obs=%b exp=%b", obs, E_NORM); end
        next_cycle();
    endtask

    task automatic test_int_defer();
        logic [9:0] e;
        i_int_req = 1'b1; i_ex_branch_taken = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== E_BR) begin failures++; $display("FAIL defer_branch obs=%b exp=%b", obs, E_BR); end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (obs !== E_NORM) begin failures++; $display("FAIL defer_run obs=%b exp=%b", obs, E_NORM); end
        next_cycle();
        @(negedge clk);
        e = INT_EN ? E_INT0 : E_NORM;
        checks++;
        if (obs !== e) begin failures++; $display("FAIL defer_enter obs=%b exp=%b", obs, e); end
        next_cycle();
        @(negedge clk);
        e = INT_EN ? E_INT1 : E_NORM;
        checks++;
        if (obs !== e) begin failures++; $display("FAIL defer_done obs=%b exp=%b", obs, e); end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [9:0] exp_seq [7];
        exp_seq[0] = E_NORM;
        exp_seq[1] = INT_EN ? E_INT0 : E_NORM;
        exp_seq[2] = INT_EN ? E_INT1 : E_NORM;
        exp_seq[3] = E_NORM;
        exp_seq[4] = INT_EN ? E_INT0 : E_NORM;
        exp_seq[5] = INT_EN ? E_INT1 : E_NORM;
        exp_seq[6] = E_NORM;
        for (int i = 0; i < 7; i++) begin
            // Requests in cycle 0 (RUN) and cycle 1 (inside the sequence).
            i_int_req = (i < 2);
            @(negedge clk);
            checks++;
            if (obs !== exp_seq[i]) begin
                failures++;
                $display("FAIL b2b_cycle%0d obs=%b exp=%b", i, obs, exp_seq[i]);
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_halt();
        logic [9:0] exp_seq [7];
        i_dec_hlt = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== E_NORM) begin failures++; $display("FAIL hlt_decode obs=%b exp=%b", obs, E_NORM); end
        next_cycle();
        i_dec_hlt = 1'b0;
        exp_seq[0] = E_HALT;
        exp_seq[1] = E_HALT;
        exp_seq[2] = E_HALT;
        exp_seq[3] = INT_EN ? E_INT0 : E_HALT;
        exp_seq[4] = INT_EN ? E_INT1 : E_HALT;
        exp_seq[5] = INT_EN ? E_NORM : E_HALT;
        exp_seq[6] = INT_EN ? E_NORM : E_HALT;
        for (int i = 0; i < 7; i++) begin
            // Interrupt pulse in the second halted cycle; branch noise later.
            i_int_req = (i == 1);
            i_ex_branch_taken = (i == 6) && !INT_EN;
            @(negedge clk);
            checks++;
            if (obs !== exp_seq[i]) begin
                failures++;
                $display("FAIL halt_cycle%0d obs=%b exp=%b", i, obs, exp_seq[i]);
            end
            next_cycle();
        end
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== E_RST) begin failures++; $display("FAIL halt_rst obs=%b exp=%b", obs, E_RST); end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== E_NORM) begin failures++; $display("FAIL halt_exit_rst obs=%b exp=%b", obs, E_NORM); end
        next_cycle();
    endtask

    task automatic test_rst_mid_int();
        i_int_req = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== E_NORM) begin failures++; $display("FAIL rmi_req obs=%b exp=%b", obs, E_NORM); end
        next_cycle();
        i_int_req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== E_RST) begin failures++; $display("FAIL rmi_rst obs=%b exp=%b", obs, E_RST); end
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== E_NORM) begin
                failures++;
                $display("FAIL rmi_after%0d obs=%b exp=%b", i, obs, E_NORM);
            end
            next_cycle();
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        next_cycle();
        test_reset();
        test_load_use();
        test_branch_lu();
        test_interrupt();
        test_int_defer();
        test_back_to_back();
        test_halt();
        test_rst_mid_int();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_pipe_hazard_ctrl
